req_gnt_clocking_bridge: RTL and testbench

- Synthesizable, cycle-accurate model of a request/grant clocking block that sits between a stimulus source and a request/grant DUT.
- Drives the DUT's `req` pin from registered drive commands, with programmable output skew in clock cycles.
- Samples the DUT's `gnt` pin through programmable input-skew flops.
- Measures request-to-grant latency for every `req` transition.

---
 rtl/req_gnt_clocking_bridge.sv | 66 ++++++
 tb/tb_req_gnt_clocking_bridge.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/req_gnt_clocking_bridge.sv
// req_gnt_clocking_bridge: skewed req drive, skewed gnt sampling and req-to-gnt latency monitor
module req_gnt_clocking_bridge #(
  parameter int IN_DELAY  = 1,
  parameter int OUT_DELAY = 1,
  parameter int LAT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             drv_en,
  input  logic             drv_val,
  input  logic             drv_toggle,
  output logic             cb_req,
  output logic             req,
  input  logic             gnt,
  output logic             cb_gnt,
  output logic             lat_valid,
  output logic [LAT_W-1:0] lat_cycles,
  output logic             overrun
);
  logic [OUT_DELAY-1:0] req_q, req_d;
  logic [IN_DELAY-1:0]  gnt_q, gnt_d;
  logic [LAT_W-1:0]     cnt_q, cnt_d, lat_cycles_q, lat_cycles_d, cnt_inc;
  logic                 pending_q, pending_d, lat_valid_q, lat_valid_d, overrun_q, overrun_d;
  logic                 change, done;
  always_comb begin
    req_d = req_q;
    req_d[0] = drv_en ? drv_val : drv_toggle ? ~req_q[0] : req_q[0];
    for (int i = 1; i < OUT_DELAY; i++) req_d[i] = req_q[i-1];
    gnt_d = gnt_q;
    gnt_d[0] = gnt;
    for (int i = 1; i < IN_DELAY; i++) gnt_d[i] = gnt_q[i-1];
    change = req_d[OUT_DELAY-1] != req_q[OUT_DELAY-1];
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    done = pending_q && !change && (gnt_d[IN_DELAY-1] == req_q[OUT_DELAY-1]);
    pending_d = change | (pending_q & ~done);
    cnt_d = change ? '0 : pending_q ? cnt_inc : cnt_q;
    lat_valid_d = done;
    lat_cycles_d = done ? cnt_inc : lat_cycles_q;
    overrun_d = overrun_q | (change & pending_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q <= '0;
      gnt_q <= '0;
      cnt_q <= '0;
      lat_cycles_q <= '0;
      pending_q <= 1'b0;
      lat_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      req_q <= req_d;
      gnt_q <= gnt_d;
      cnt_q <= cnt_d;
      lat_cycles_q <= lat_cycles_d;
      pending_q <= pending_d;
      lat_valid_q <= lat_valid_d;
      overrun_q <= overrun_d;
    end
  end
  assign cb_req     = req_q[0];
  assign req        = req_q[OUT_DELAY-1];
  assign cb_gnt     = gnt_q[IN_DELAY-1];
  assign lat_valid  = lat_valid_q;
  assign lat_cycles = lat_cycles_q;
  assign overrun    = overrun_q;
endmodule

// File: tb/tb_req_gnt_clocking_bridge.sv
// tb_req_gnt_clocking_bridge: directed vector bench for req_gnt_clocking_bridge
module tb_req_gnt_clocking_bridge;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en1 = 1'b0, val1 = 1'b0, tog1 = 1'b0;
  logic cbr1, req1, gnt1, cbg1, lv1, ov1;
  logic [7:0] lc1;
  logic en2 = 1'b0, val2 = 1'b0, tog2 = 1'b0;
  logic cbr2, req2, gnt2, cbg2, lv2, ov2;
  logic [7:0] lc2;
  logic loop_q = 1'b0;
  logic stuck = 1'b0, force_g = 1'b0;
  int n_vec = 0, n_fail = 0;
  always #5 clk = ~clk;
  always @(posedge clk) loop_q <= rst ? 1'b0 : req1;
  assign gnt1 = stuck ? force_g : loop_q;
  assign gnt2 = req2;
  req_gnt_clocking_bridge dut1 (
    .clk(clk), .rst(rst), .drv_en(en1), .drv_val(val1), .drv_toggle(tog1),
    .cb_req(cbr1), .req(req1), .gnt(gnt1), .cb_gnt(cbg1),
    .lat_valid(lv1), .lat_cycles(lc1), .overrun(ov1)
  );
  req_gnt_clocking_bridge #(.IN_DELAY(2), .OUT_DELAY(3), .LAT_W(8)) dut2 (
    .clk(clk), .rst(rst), .drv_en(en2), .drv_val(val2), .drv_toggle(tog2),
    .cb_req(cbr2), .req(req2), .gnt(gnt2), .cb_gnt(cbg2),
    .lat_valid(lv2), .lat_cycles(lc2), .overrun(ov2)
  );
  typedef struct packed {
    logic rst, en, val, tog, cbr, rq, cbg, lv;
    logic [7:0] lc;
    logic ov;
  } vec_t;
  vec_t tbl[24];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  int pulses;
  task automatic step();
    @(posedge clk);
    #1;
    if (lv1) begin
      pulses++;
      chk("toggle.lat_cycles", 32'(lc1), 32'd2);
    end
  endtask
  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    int gaps[10] = '{3, 0, 5, 15, 1, 2, 7, 0, 9, 4};
    int stray;
    tbl[0]  = {4'b1110, 4'b0000, 8'd0, 1'b0};
    tbl[1]  = {4'b1110, 4'b0000, 8'd0, 1'b0};
    tbl[2]  = {4'b0110, 4'b1100, 8'd0, 1'b0};
    tbl[3]  = {4'b0000, 4'b1100, 8'd0, 1'b0};
    tbl[4]  = {4'b0000, 4'b1111, 8'd2, 1'b0};
    tbl[5]  = {4'b0000, 4'b1110, 8'd2, 1'b0};
    tbl[6]  = {4'b0110, 4'b1110, 8'd2, 1'b0};
    tbl[7]  = {4'b0001, 4'b0010, 8'd2, 1'b0};
    tbl[8]  = {4'b0000, 4'b0010, 8'd2, 1'b0};
    tbl[9]  = {4'b0000, 4'b0001, 8'd2, 1'b0};
    tbl[10] = {4'b0101, 4'b0000, 8'd2, 1'b0};
    tbl[11] = {4'b0000, 4'b0000, 8'd2, 1'b0};
    tbl[12] = {4'b0001, 4'b1100, 8'd2, 1'b0};
    tbl[13] = {4'b0000, 4'b1100, 8'd2, 1'b0};
    tbl[14] = {4'b0000, 4'b1111, 8'd2, 1'b0};
    tbl[15] = {4'b0001, 4'b0010, 8'd2, 1'b0};
    tbl[16] = {4'b0001, 4'b1110, 8'd2, 1'b1};
    tbl[17] = {4'b0000, 4'b1100, 8'd2, 1'b1};
    tbl[18] = {4'b0000, 4'b1111, 8'd2, 1'b1};
    tbl[19] = {4'b1000, 4'b0000, 8'd0, 1'b0};
    tbl[20] = {4'b0001, 4'b1100, 8'd0, 1'b0};
    tbl[21] = {4'b1000, 4'b0000, 8'd0, 1'b0};
    tbl[22] = {4'b0000, 4'b0000, 8'd0, 1'b0};
    tbl[23] = {4'b0000, 4'b0000, 8'd0, 1'b0};
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      rst = tbl[i].rst; en1 = tbl[i].en; val1 = tbl[i].val; tog1 = tbl[i].tog;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.cb_req", i), 32'(cbr1), 32'(tbl[i].cbr));
      chk($sformatf("v%0d.req", i), 32'(req1), 32'(tbl[i].rq));
      chk($sformatf("v%0d.cb_gnt", i), 32'(cbg1), 32'(tbl[i].cbg));
      chk($sformatf("v%0d.lat_valid", i), 32'(lv1), 32'(tbl[i].lv));
      chk($sformatf("v%0d.lat_cycles", i), 32'(lc1), 32'(tbl[i].lc));
      chk($sformatf("v%0d.overrun", i), 32'(ov1), 32'(tbl[i].ov));
    end
    @(negedge clk);
    rst = 1'b0; en1 = 1'b0; val1 = 1'b0; tog1 = 1'b0;
    pulse_rst();
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tog1 = 1'b1;
      step();
      tog1 = 1'b0;
      for (int g = 0; g < gaps[i]; g++) step();
    end
    for (int g = 0; g < 6; g++) step();
    chk("toggle.pulses", 32'(pulses), 32'd7);
    chk("toggle.overrun", 32'(ov1), 32'd1);
    pulse_rst();
    stuck = 1'b1;
    force_g = 1'b0;
    @(negedge clk);
    tog1 = 1'b1;
    @(posedge clk);
    #1;
    tog1 = 1'b0;
    stray = 0;
    for (int g = 0; g < 300; g++) begin
      @(posedge clk);
      #1;
      if (lv1) stray++;
    end
    chk("stuck.no_pulse", 32'(stray), 32'd0);
    chk("stuck.counter", 32'(dut1.cnt_q), 32'd255);
    chk("stuck.req", 32'(req1), 32'd1);
    force_g = 1'b1;
    @(posedge clk);
    #1;
    chk("stuck.release_valid", 32'(lv1), 32'd1);
    chk("stuck.release_cycles", 32'(lc1), 32'd255);
    stuck = 1'b0;
    pulse_rst();
    chk("skew.reset_req", 32'(req2), 32'd0);
    @(negedge clk);
    en2 = 1'b1;
    val2 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      en2 = 1'b0;
      chk($sformatf("skew.e%0d.cb_req", k), 32'(cbr2), 32'd1);
      chk($sformatf("skew.e%0d.req", k), 32'(req2), 32'(k >= 2));
      chk($sformatf("skew.e%0d.cb_gnt", k), 32'(cbg2), 32'(k >= 4));
      chk($sformatf("skew.e%0d.lat_valid", k), 32'(lv2), 32'(k == 4));
      chk($sformatf("skew.e%0d.lat_cycles", k), 32'(lc2), (k >= 4) ? 32'd2 : 32'd0);
    end
    chk("skew.overrun", 32'(ov2), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
